regfile_write_ctrl: RTL and testbench

Write-port controller for the 4×16 register file. It owns the file's single write port (RegWrite/RD/WriteData) and shares it between two writeback requesters, ALU and memory-load, using valid/ready handshakes and round-robin arbitration. After reset, or on request, it runs a zero-clear sweep of every register, so the register file needs no initial block for reset state. It sits between the execute/memory writeback paths and the register file.

---
 rtl/regfile_ctrl_pkg.sv | 21 ++
 rtl/regfile_write_ctrl_arb.sv | 28 ++
 rtl/regfile_write_ctrl.sv | 120 ++++++++++++
 tb/tb_regfile_write_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg
//   Shared types and default sizes for the register-file write-port
//   controller.
//   - state_e : controller state (CLEAR sweep / RUN arbitration)
//   - req_e   : writeback requester identity, used for round-robin priority
package regfile_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 2;

endpackage

// File: rtl/regfile_write_ctrl_arb.sv
// rr_arbiter2
//   Two-way round-robin arbiter, purely combinational.
//   Ports:
//     req_alu_i   - ALU request
//     req_mem_i   - memory-load request
//     priority_i  - requester that wins when both request
//     grant_o     - one-hot grant, bit 0 = ALU, bit 1 = MEM
//     contended_o - both requested; the caller uses it to rotate priority
module rr_arbiter2
    import regfile_ctrl_pkg::*;
(
    input  logic       req_alu_i,
    input  logic       req_mem_i,
    input  req_e       priority_i,
    output logic [1:0] grant_o,
    output logic       contended_o
);

    always_comb begin
        contended_o = req_alu_i && req_mem_i;
        if (contended_o) begin
            grant_o = (priority_i == REQ_ALU) ? 2'b01 : 2'b10;
        end else begin
            grant_o = {req_mem_i, req_alu_i};
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl
//   Owns the single write port of the register file. After reset (or a
//   ClearReq pulse) it sweeps zeros into every register, then shares the
//   port between the ALU and memory-load writeback paths with round-robin
//   arbitration.
//   Ports:
//     Clock, ResetN             - clock, asynchronous active-low reset
//     ClearReq                  - pulse: (re)start the zero-clear sweep
//     AluValid/AluRD/AluData    - ALU writeback request
//     AluReady                  - ALU request accepted this cycle
//     MemValid/MemRD/MemData    - load writeback request
//     MemReady                  - load request accepted this cycle
//     RegWrite/RD/WriteData     - registered register-file write port
//     ClearDone                 - high while in RUN
module regfile_write_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  ClearReq,
    input  logic                  AluValid,
    input  logic [ADDR_WIDTH-1:0] AluRD,
    input  logic [DATA_WIDTH-1:0] AluData,
    output logic                  AluReady,
    input  logic                  MemValid,
    input  logic [ADDR_WIDTH-1:0] MemRD,
    input  logic [DATA_WIDTH-1:0] MemData,
    output logic                  MemReady,
    output logic                  RegWrite,
    output logic [ADDR_WIDTH-1:0] RD,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  ClearDone
);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   clear_cnt_q;
    req_e                    prio_q;
    req_e                    prio_d;
    logic                    regwrite_q;
    logic [ADDR_WIDTH-1:0]   rd_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    done_q;

    logic [1:0]              grant;
    logic                    contended;
    logic                    accept_en;

    rr_arbiter2 u_arb (
        .req_alu_i   (AluValid),
        .req_mem_i   (MemValid),
        .priority_i  (prio_q),
        .grant_o     (grant),
        .contended_o (contended)
    );

    // Readys depend only on inputs and state/priority flops, never on the
    // registered write port, so no ready->valid loop can form upstream.
    always_comb begin
        accept_en = (state_q == RUN) && !ClearReq;
        AluReady  = accept_en && grant[0];
        MemReady  = accept_en && grant[1];
        prio_d    = prio_q;
        if (accept_en && contended) begin
            prio_d = grant[0] ? REQ_MEM : REQ_ALU;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= CLEAR;
            clear_cnt_q <= '0;
            prio_q      <= REQ_ALU;
            regwrite_q  <= 1'b0;
            rd_q        <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
        end else if (ClearReq) begin
            // Restart from index 0 in either state; nothing is written on
            // the restart edge itself.
            state_q     <= CLEAR;
            clear_cnt_q <= '0;
            regwrite_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    regwrite_q  <= 1'b1;
                    rd_q        <= clear_cnt_q;
                    wdata_q     <= '0;
                    clear_cnt_q <= clear_cnt_q + 1'b1;
                    if (clear_cnt_q == '1) begin
                        state_q <= RUN;
                        done_q  <= 1'b1;
                    end
                end
                RUN: begin
                    regwrite_q <= AluReady || MemReady;
                    prio_q     <= prio_d;
                    if (AluReady) begin
                        rd_q    <= AluRD;
                        wdata_q <= AluData;
                    end else if (MemReady) begin
                        rd_q    <= MemRD;
                        wdata_q <= MemData;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign RegWrite  = regwrite_q;
    assign RD        = rd_q;
    assign WriteData = wdata_q;
    assign ClearDone = done_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
module tb_regfile_write_ctrl;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic        ClearReq;
    logic        AluValid;
    logic [1:0]  AluRD;
    logic [15:0] AluData;
    logic        AluReady;
    logic        MemValid;
    logic [1:0]  MemRD;
    logic [15:0] MemData;
    logic        MemReady;
    logic        RegWrite;
    logic [1:0]  RD;
    logic [15:0] WriteData;
    logic        ClearDone;

    regfile_write_ctrl #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (2)
    ) dut (
        .Clock     (Clock),
        .ResetN    (ResetN),
        .ClearReq  (ClearReq),
        .AluValid  (AluValid),
        .AluRD     (AluRD),
        .AluData   (AluData),
        .AluReady  (AluReady),
        .MemValid  (MemValid),
        .MemRD     (MemRD),
        .MemData   (MemData),
        .MemReady  (MemReady),
        .RegWrite  (RegWrite),
        .RD        (RD),
        .WriteData (WriteData),
        .ClearDone (ClearDone)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0]  rd;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model of the controller's visible state
    logic       m_run;
    logic [1:0] m_cnt;
    logic       m_prio;   // 0 = ALU, 1 = MEM

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_cnt  = 2'd0;
        m_prio = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: inputs already driven; check readys, push expected
    // writes, step past the edge and check the write port.
    task automatic cycle();
        logic exp_alu, exp_mem, acc;
        wr_t  w, e;
        #1;
        acc     = m_run && !ClearReq;
        exp_alu = acc && AluValid && (!MemValid || !m_prio);
        exp_mem = acc && MemValid && (!AluValid || m_prio);
        check("alu_ready", AluReady, exp_alu);
        check("mem_ready", MemReady, exp_mem);
        if (ClearReq) begin
            m_run = 1'b0;
            m_cnt = 2'd0;
        end else if (!m_run) begin
            w.rd = m_cnt; w.data = 16'h0000;
            exp_q.push_back(w);
            if (m_cnt == 2'd3) m_run = 1'b1;
            m_cnt = m_cnt + 2'd1;
        end else begin
            if (exp_alu) begin
                w.rd = AluRD; w.data = AluData;
                exp_q.push_back(w);
            end else if (exp_mem) begin
                w.rd = MemRD; w.data = MemData;
                exp_q.push_back(w);
            end
            if (AluValid && MemValid) m_prio = exp_alu;
        end
        @(posedge Clock);
        #1;
        check("clear_done", ClearDone, m_run);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_en", RegWrite, 1'b1);
            check("wr_rd", RD, e.rd);
            check("wr_data", WriteData, e.data);
        end else if (RegWrite) begin
            check("wr_spurious", RegWrite, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        ResetN   = 1'b0;
        ClearReq = 1'b0;
        AluValid = 1'b0; AluRD = 2'd0; AluData = 16'h0;
        MemValid = 1'b0; MemRD = 2'd0; MemData = 16'h0;
        model_reset();
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        check("rst_regwrite", RegWrite, 1'b0);
        check("rst_rd", RD, 2'd0);
        check("rst_wdata", WriteData, 16'h0);
        check("rst_done", ClearDone, 1'b0);
        check("rst_alu_ready", AluReady, 1'b0);
        check("rst_mem_ready", MemReady, 1'b0);

        // Reset sweep then one idle cycle
        ResetN = 1'b1;
        repeat (5) cycle();
        check("idle_regwrite", RegWrite, 1'b0);

        // Single ALU write
        AluValid = 1'b1; AluRD = 2'd2; AluData = 16'hBEEF;
        cycle();
        AluValid = 1'b0;
        cycle();
        check("hold_rd", RD, 2'd2);
        check("hold_wdata", WriteData, 16'hBEEF);

        // Sustained contention on the same RD: grants alternate
        AluValid = 1'b1; AluRD = 2'd1; AluData = 16'h0001;
        MemValid = 1'b1; MemRD = 2'd1; MemData = 16'h0002;
        repeat (4) cycle();
        check("final_data", WriteData, 16'h0002);
        // Priority should be back at ALU: one more contended cycle
        AluData = 16'h0A0A; MemData = 16'h0B0B;
        cycle();
        AluValid = 1'b0;
        cycle();
        MemValid = 1'b0;
        cycle();

        // ClearReq while MEM is waiting
        MemValid = 1'b1; MemRD = 2'd3; MemData = 16'h1234;
        ClearReq = 1'b1;
        cycle();
        ClearReq = 1'b0;
        repeat (5) cycle();
        MemValid = 1'b0;
        cycle();

        // ClearReq re-pulsed at sweep index 2
        ClearReq = 1'b1;
        cycle();
        ClearReq = 1'b0;
        repeat (2) cycle();
        ClearReq = 1'b1;
        cycle();
        ClearReq = 1'b0;
        repeat (5) cycle();

        // Reset during an ALU transfer
        AluValid = 1'b1; AluRD = 2'd1; AluData = 16'hCAFE;
        cycle();
        AluRD = 2'd2; AluData = 16'h5555;
        #2;
        ResetN = 1'b0;
        #1;
        check("arst_regwrite", RegWrite, 1'b0);
        check("arst_rd", RD, 2'd0);
        check("arst_wdata", WriteData, 16'h0);
        check("arst_done", ClearDone, 1'b0);
        check("arst_alu_ready", AluReady, 1'b0);
        model_reset();
        @(posedge Clock); #1;
        ResetN = 1'b1;
        repeat (5) cycle();
        AluValid = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
